// File: rtl/riscv_pkg.sv
// Shared LSU definitions: RV32I load/store width codes, FSM states, request payload
// and access-size helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  typedef struct packed {
    logic            is_load;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Undefined width codes fall through to a word access.
  function automatic lsu_size_t size_of(input logic [2:0] funct3);
    case (funct3)
      LB, LBU: return SZ_BYTE;
      LH, LHU: return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (size_of(funct3))
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering for the LSU: byte enables, store-data replication and load-data
// shift with sign/zero extension. Purely combinational.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  lsu_size_t   size_c;
  logic [1:0]  off_c;
  logic [31:0] shifted_c;
  logic        sext_c;

  // Offset bits that would split a halfword/word are dropped.
  always_comb begin
    size_c = size_of(funct3);
    case (size_c)
      SZ_HALF: off_c = {offset[1], 1'b0};
      SZ_WORD: off_c = 2'b00;
      default: off_c = offset;
    endcase
  end

  assign shifted_c = rdata >> {off_c, 3'b000};
  assign sext_c    = ~funct3[2];

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    rdata_c = shifted_c;
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{sext_c & shifted_c[7]}}, shifted_c[7:0]};
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = {{16{sext_c & shifted_c[15]}}, shifted_c[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one outstanding access, req/gnt + rvalid memory port.
// Optional RISCV_LSU_MISALIGN_TRAP_EN reports misaligned accesses instead of aligning them.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  input  logic              lsu_is_load,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              accept_c, trap_c, unused_addr_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, rdata_c;
  logic              ready_d, done_d, mis_d, mreq_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        be_d;
  logic [31:0]       mwdata_d, rdata_d;

  assign accept_c = lsu_valid & lsu_ready;
  assign req_d    = accept_c ? lsu_req_t'{is_load: lsu_is_load, funct3: lsu_funct3,
                                          addr: lsu_addr, wdata: lsu_wdata}
                             : req_q;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign trap_c = misaligned(req_d.funct3, req_d.addr[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  assign unused_addr_c = ^req_d.addr[31:ADDR_W+2];

  riscv_lsu_align u_align (
    .funct3  (req_d.funct3),
    .offset  (req_d.addr[1:0]),
    .wdata   (req_d.wdata),
    .rdata   (mem_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_q          <= '0;
      lsu_ready      <= 1'b1;
      lsu_done       <= 1'b0;
      lsu_misaligned <= 1'b0;
      lsu_rdata      <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= '0;
      mem_wdata      <= '0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      lsu_ready      <= ready_d;
      lsu_done       <= done_d;
      lsu_misaligned <= mis_d;
      lsu_rdata      <= rdata_d;
      mem_req        <= mreq_d;
      mem_we         <= we_d;
      mem_addr       <= addr_d;
      mem_be         <= be_d;
      mem_wdata      <= mwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = trap_c ? DONE : REQ;
      REQ:     if (mem_gnt) state_d = req_q.is_load ? WAIT : DONE;
      WAIT:    if (mem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered; load data only arrives via WAIT.
  always_comb begin
    ready_d  = 1'b0;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    mreq_d   = 1'b0;
    we_d     = 1'b0;
    addr_d   = '0;
    be_d     = '0;
    mwdata_d = '0;
    rdata_d  = '0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      REQ: begin
        mreq_d   = 1'b1;
        we_d     = ~req_d.is_load;
        addr_d   = req_d.addr[ADDR_W+1:2];
        be_d     = be_c;
        mwdata_d = wdata_c;
      end
      DONE: begin
        done_d = 1'b1;
        mis_d  = trap_c;
        if (state_q == WAIT) rdata_d = rdata_c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu against a byte-lane reference model.
// Honours RISCV_LSU_MISALIGN_TRAP_EN to match the DUT build.
module tb_riscv_lsu;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W = 10;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk, rst_n;
  logic              lsu_valid, lsu_is_load;
  logic [2:0]        lsu_funct3;
  logic [31:0]       lsu_addr, lsu_wdata;
  logic              lsu_ready, lsu_done, lsu_misaligned;
  logic [31:0]       lsu_rdata;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;

  riscv_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_is_load(lsu_is_load), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misaligned(lsu_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations of the last transaction
  int                obs_lat, obs_reqc;
  bit                obs_stable, obs_rdy_busy, obs_post_ok;
  logic              obs_mis, obs_we;
  logic [31:0]       obs_rdata, obs_wdata;
  logic [ADDR_W-1:0] obs_addr;
  logic [3:0]        obs_be;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a[1:0]);
    return off - (off % m_size(f3));
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    return TRAP && ((int'(a[1:0]) % m_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    int n = m_size(f3), off = m_off(f3, a);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    int n = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [63:0] v = '0;
    int n = m_size(f3), off = m_off(f3, a);
    for (int k = 0; k < n; k++) v = v | (64'(w[8*(off+k) +: 8]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  // ---------------- transaction driver (records, does not judge) ----------------
  task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rvd,
                         input logic [31:0] rd);
    int  wcnt = 0;
    bit  granted = 0;
    obs_lat = -1; obs_reqc = 0; obs_stable = 1; obs_rdy_busy = 0; obs_post_ok = 0;
    obs_mis = 0; obs_we = 0; obs_rdata = '0; obs_wdata = '0; obs_addr = '0; obs_be = '0;
    lsu_valid = 1'b1; lsu_is_load = ld; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    @(negedge clk);
    for (int c = 1; c <= 300; c++) begin
      // garbage on the request port while busy must be ignored
      lsu_valid = 1'($urandom); lsu_is_load = 1'($urandom); lsu_funct3 = 3'($urandom);
      lsu_addr = $urandom; lsu_wdata = $urandom;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (lsu_ready) obs_rdy_busy = 1;
      if (lsu_done) begin
        obs_lat = c; obs_rdata = lsu_rdata; obs_mis = lsu_misaligned;
        if (mem_req) obs_stable = 0;
        break;
      end
      if (mem_req) begin
        if (obs_reqc == 0) begin
          obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {obs_we, obs_addr, obs_be, obs_wdata})
          obs_stable = 0;
        obs_reqc++;
        if (obs_reqc > gd) begin mem_gnt = 1'b1; granted = 1; end
        else if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
      end else if (granted) begin
        wcnt++;
        if (wcnt > rvd) begin mem_rvalid = 1'b1; mem_rdata = rd; end
      end
      @(negedge clk);
    end
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    obs_post_ok = (lsu_done === 1'b0) && (lsu_ready === 1'b1) && (mem_req === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; lsu_valid = 1'b1; lsu_is_load = 1'b0; lsu_funct3 = SW;
    lsu_addr = 32'h10; lsu_wdata = 32'h1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
    repeat (3) @(negedge clk);
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
    n_vec++; if (lsu_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", lsu_done); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_vec++; if ({mem_we, mem_addr, mem_be, mem_wdata, lsu_rdata, lsu_misaligned} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got we=%b addr=%h be=%b wd=%h rd=%h mis=%b want all 0",
                        mem_we, mem_addr, mem_be, mem_wdata, lsu_rdata, lsu_misaligned);
    end
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", lsu_ready); end
  endtask

  task automatic test_store_word();
    run_txn(1'b0, SW, 32'h10, 32'hDEADBEEF, 0, 0, '0);
    n_vec++; if (obs_lat !== 2) begin n_err++; $display("FAIL sw_latency: got %0d want 2", obs_lat); end
    n_vec++; if (obs_addr !== 10'd4) begin n_err++; $display("FAIL sw_addr: got %h want 004", obs_addr); end
    n_vec++; if (obs_be !== 4'b1111) begin n_err++; $display("FAIL sw_be: got %b want 1111", obs_be); end
    n_vec++; if (obs_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata); end
    n_vec++; if (obs_we !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b want 1", obs_we); end
    n_vec++; if (obs_rdata !== 32'h0) begin n_err++; $display("FAIL sw_rdata: got %h want 0", obs_rdata); end
    n_vec++; if (!obs_post_ok) begin n_err++; $display("FAIL sw_done_pulse: got post-done state not idle want idle"); end
  endtask

  task automatic test_store_byte();
    run_txn(1'b0, SB, 32'h13, 32'h000000A5, 0, 0, '0);
    n_vec++; if (obs_be !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b want 1000", obs_be); end
    n_vec++; if (obs_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
    n_vec++; if (obs_addr !== 10'd4) begin n_err++; $display("FAIL sb_addr: got %h want 004", obs_addr); end
  endtask

  task automatic test_load_ext();
    run_txn(1'b1, LB, 32'h22, 32'h0, 0, 3, 32'h12F03456);
    n_vec++; if (obs_rdata !== 32'hFFFFFFF0) begin n_err++; $display("FAIL lb_rdata: got %h want fffffff0", obs_rdata); end
    n_vec++; if (obs_lat !== 6) begin n_err++; $display("FAIL lb_latency: got %0d want 6", obs_lat); end
    n_vec++; if (obs_we !== 1'b0 || obs_be !== 4'b0100) begin n_err++; $display("FAIL lb_req: got we=%b be=%b want we=0 be=0100", obs_we, obs_be); end
    run_txn(1'b1, LBU, 32'h22, 32'h0, 0, 3, 32'h12F03456);
    n_vec++; if (obs_rdata !== 32'h000000F0) begin n_err++; $display("FAIL lbu_rdata: got %h want 000000f0", obs_rdata); end
    run_txn(1'b1, LW, 32'h44, 32'h0, 0, 0, 32'h89ABCDEF);
    n_vec++; if (obs_lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", obs_lat); end
    n_vec++; if (obs_rdata !== 32'h89ABCDEF) begin n_err++; $display("FAIL lw_rdata: got %h want 89abcdef", obs_rdata); end
  endtask

  task automatic test_misaligned();
    int exp_reqc, exp_lat;
    logic exp_mis;
    logic [3:0] exp_be;
    logic [31:0] exp_rd;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    exp_reqc = 0; exp_lat = 1; exp_mis = 1'b1; exp_be = 4'b0000; exp_rd = 32'h0;
`else
    exp_reqc = 1; exp_lat = 3; exp_mis = 1'b0; exp_be = 4'b0011; exp_rd = 32'hFFFF8001;
`endif
    run_txn(1'b1, LH, 32'h21, 32'h0, 0, 0, 32'h00008001);
    n_vec++; if (obs_reqc !== exp_reqc) begin n_err++; $display("FAIL lh_mis_reqs: got %0d want %0d", obs_reqc, exp_reqc); end
    n_vec++; if (obs_mis !== exp_mis) begin n_err++; $display("FAIL lh_mis_flag: got %b want %b", obs_mis, exp_mis); end
    n_vec++; if (obs_lat !== exp_lat) begin n_err++; $display("FAIL lh_mis_latency: got %0d want %0d", obs_lat, exp_lat); end
    n_vec++; if (obs_be !== exp_be) begin n_err++; $display("FAIL lh_mis_be: got %b want %b", obs_be, exp_be); end
    n_vec++; if (obs_rdata !== exp_rd) begin n_err++; $display("FAIL lh_mis_rdata: got %h want %h", obs_rdata, exp_rd); end
  endtask

  task automatic test_gnt_stall();
    int dn = 0;
    run_txn(1'b0, SH, 32'h06, 32'h1234BEEF, 5, 0, '0);
    n_vec++; if (obs_reqc !== 6) begin n_err++; $display("FAIL stall_req_cycles: got %0d want 6", obs_reqc); end
    n_vec++; if (!obs_stable) begin n_err++; $display("FAIL stall_stable: got payload change want stable"); end
    n_vec++; if (obs_rdy_busy) begin n_err++; $display("FAIL stall_ready: got ready=1 while busy want 0"); end
    n_vec++; if (obs_lat !== 7) begin n_err++; $display("FAIL stall_latency: got %0d want 7", obs_lat); end
    n_vec++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hBEEFBEEF) begin
      n_err++; $display("FAIL stall_payload: got be=%b wd=%h want be=1100 wd=beefbeef", obs_be, obs_wdata);
    end
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b1; mem_gnt = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      if (lsu_done || mem_req) dn++;
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL stray_rvalid: got %0d done/req cycles want 0", dn); end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    lsu_valid = 1'b1; lsu_is_load = 1'b1; lsu_funct3 = LW; lsu_addr = 32'h40; lsu_wdata = '0;
    @(negedge clk);
    lsu_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_vec++; if ({lsu_ready, lsu_done, mem_req} !== 3'b000) begin
      n_err++; $display("FAIL wait_state: got ready/done/req=%b%b%b want 000", lsu_ready, lsu_done, mem_req);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", lsu_ready); end
    n_vec++; if ({lsu_done, mem_req, lsu_rdata, lsu_misaligned} !== '0) begin
      n_err++; $display("FAIL midrst_clear: got done=%b req=%b rd=%h want 0", lsu_done, mem_req, lsu_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      if (lsu_done) dn++;
    end
    mem_rvalid = 1'b0;
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dn); end
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after: got %b want 1", lsu_ready); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 80; t++) begin
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd, exp_rd;
      int          gd, rvd, exp_lat;
      bit          mis;
      ld  = 1'($urandom);
      f3  = ld ? 3'($urandom) : 3'($urandom_range(0, 3));
      a   = $urandom; wd = $urandom; rd = $urandom;
      gd  = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
      mis = m_mis(f3, a);
      exp_lat = mis ? 1 : (ld ? gd + rvd + 3 : gd + 2);
      exp_rd  = (ld && !mis) ? m_rdata(f3, a, rd) : 32'h0;
      run_txn(ld, f3, a, wd, gd, rvd, rd);
      n_vec++; if (obs_lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, obs_lat, exp_lat); end
      n_vec++; if (obs_mis !== mis) begin n_err++; $display("FAIL rnd%0d_mis: got %b want %b", t, obs_mis, mis); end
      n_vec++; if (obs_rdata !== exp_rd) begin n_err++; $display("FAIL rnd%0d_rdata: got %h want %h (f3=%b a=%h mem=%h)", t, obs_rdata, exp_rd, f3, a, rd); end
      n_vec++; if (!obs_post_ok || !obs_stable || obs_rdy_busy) begin
        n_err++; $display("FAIL rnd%0d_handshake: got post=%b stable=%b busy_ready=%b want 1 1 0", t, obs_post_ok, obs_stable, obs_rdy_busy);
      end
      if (!mis) begin
        n_vec++; if (obs_addr !== a[ADDR_W+1:2] || obs_we !== !ld) begin
          n_err++; $display("FAIL rnd%0d_addr: got addr=%h we=%b want addr=%h we=%b", t, obs_addr, obs_we, a[ADDR_W+1:2], !ld);
        end
        n_vec++; if (obs_be !== m_be(f3, a)) begin n_err++; $display("FAIL rnd%0d_be: got %b want %b", t, obs_be, m_be(f3, a)); end
        if (!ld) begin
          n_vec++; if (obs_wdata !== m_wdata(f3, wd)) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", t, obs_wdata, m_wdata(f3, wd)); end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_is_load = 1'b0; lsu_funct3 = '0; lsu_addr = '0;
    lsu_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_ext();
    test_misaligned();
    test_gnt_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
